// File: rtl/arm7tdmi_prefetch_buffer.sv
// Purpose : ARM7TDMI fetch front end. Holds the fetch PC, issues sequential ARM (+4) or
//           Thumb (+2) requests to the I-cache, and queues returned instructions with
//           their PC and Thumb state in a DEPTH-entry FIFO. A branch flushes the FIFO
//           and redirects the PC.
// Latency : one cycle from cache transfer to dec_valid. dec_* is driven combinationally
//           from the FIFO head.
// Backpressure: decode stalls with dec_ready=0. When the FIFO fills, the block drops
//           icache_req. icache_req is decoded from registered state only.
// Ports   : clk/rst (sync, active high); fetch_enable; branch_valid/addr/thumb;
//           icache_addr/req/thumb_mode out, icache_data/ready in;
//           dec_valid/instr/pc/thumb out, dec_ready in; occupancy out.
//           Optional macro PREFETCH_STATS_EN adds stat_fetches, stat_flushes and
//           stat_discards (32-bit, wrapping).
module arm7tdmi_prefetch_buffer #(
   parameter int unsigned            DEPTH        = 4,
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_enable,
   input  logic                       branch_valid,
   input  logic [ADDR_WIDTH-1:0]      branch_addr,
   input  logic                       branch_thumb,
   output logic [ADDR_WIDTH-1:0]      icache_addr,
   output logic                       icache_req,
   output logic                       icache_thumb_mode,
   input  logic [31:0]                icache_data,
   input  logic                       icache_ready,
   output logic                       dec_valid,
   output logic [31:0]                dec_instr,
   output logic [ADDR_WIDTH-1:0]      dec_pc,
   output logic                       dec_thumb,
   input  logic                       dec_ready,
`ifdef PREFETCH_STATS_EN
   output logic [31:0]                stat_fetches,
   output logic [31:0]                stat_flushes,
   output logic [31:0]                stat_discards,
`endif
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic                   thumb_q, thumb_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic [31:0]            mem_instr_q [DEPTH];
   logic [ADDR_WIDTH-1:0]  mem_pc_q    [DEPTH];
   logic                   mem_thumb_q [DEPTH];

   logic                   xfer;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic [ADDR_WIDTH-1:0]  branch_tgt;

   assign fifo_full  = (cnt_q == CW'(DEPTH));
   assign icache_req = (state_q == S_FETCH);
   assign xfer       = icache_req && icache_ready;
   // A branch cancels both a coinciding transfer and a coinciding pop.
   assign push       = xfer && !fifo_full && !branch_valid;
   assign pop        = dec_valid && dec_ready && !branch_valid;

   // Clear the low address bits that cannot hold an instruction in the target state.
   assign branch_tgt = branch_thumb ? {branch_addr[ADDR_WIDTH-1:1], 1'b0}
                                    : {branch_addr[ADDR_WIDTH-1:2], 2'b00};

   assign icache_addr       = pc_q;
   assign icache_thumb_mode = thumb_q;
   assign occupancy         = cnt_q;
   assign dec_valid         = (cnt_q != '0);

   // The storage is not reset. The head is masked so the outputs read zero when empty.
   assign dec_instr = dec_valid ? mem_instr_q[rd_ptr_q] : '0;
   assign dec_pc    = dec_valid ? mem_pc_q[rd_ptr_q]    : '0;
   assign dec_thumb = dec_valid && mem_thumb_q[rd_ptr_q];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      thumb_d  = thumb_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (fetch_enable) state_d = S_FETCH;
         end
         S_FETCH: begin
            // Filling the last slot takes priority over fetch_enable dropping.
            if (push && !pop && (cnt_q == CW'(DEPTH - 1))) state_d = S_FULL;
            else if (!fetch_enable)                        state_d = S_IDLE;
         end
         S_FULL: begin
            if (pop) state_d = fetch_enable ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         pc_d     = pc_q + (thumb_q ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      if (branch_valid) begin
         state_d  = fetch_enable ? S_FETCH : S_IDLE;
         pc_d     = branch_tgt;
         thumb_d  = branch_thumb;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_VECTOR;
         thumb_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         thumb_q  <= thumb_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_instr_q[wr_ptr_q] <= icache_data;
         mem_pc_q[wr_ptr_q]    <= pc_q;
         mem_thumb_q[wr_ptr_q] <= thumb_q;
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_fetches_q, stat_flushes_q, stat_discards_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetches_q  <= '0;
         stat_flushes_q  <= '0;
         stat_discards_q <= '0;
      end else begin
         // Transfers killed by a branch still count as fetches.
         if (xfer) stat_fetches_q <= stat_fetches_q + 32'd1;
         if (branch_valid) begin
            stat_flushes_q  <= stat_flushes_q + 32'd1;
            stat_discards_q <= stat_discards_q + 32'(cnt_q) + 32'(xfer);
         end
      end
   end

   assign stat_fetches  = stat_fetches_q;
   assign stat_flushes  = stat_flushes_q;
   assign stat_discards = stat_discards_q;
`endif

endmodule

// File: tb/tb_arm7tdmi_prefetch_buffer.sv
// Purpose : directed self-checking bench for arm7tdmi_prefetch_buffer (DEPTH=4).
// Latency : inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: the cache model answers with a data word derived from the address.
module tb_arm7tdmi_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_enable;
   logic        branch_valid;
   logic [31:0] branch_addr;
   logic        branch_thumb;
   logic [31:0] icache_addr;
   logic        icache_req;
   logic        icache_thumb_mode;
   logic [31:0] icache_data;
   logic        icache_ready;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_thumb;
   logic        dec_ready;
   logic [2:0]  occupancy;
`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_fetches, stat_flushes, stat_discards;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // The cache returns a recognisable word for each address.
   assign icache_data = 32'hE000_0000 | icache_addr;

   arm7tdmi_prefetch_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
      .clk               (clk),
      .rst               (rst),
      .fetch_enable      (fetch_enable),
      .branch_valid      (branch_valid),
      .branch_addr       (branch_addr),
      .branch_thumb      (branch_thumb),
      .icache_addr       (icache_addr),
      .icache_req        (icache_req),
      .icache_thumb_mode (icache_thumb_mode),
      .icache_data       (icache_data),
      .icache_ready      (icache_ready),
      .dec_valid         (dec_valid),
      .dec_instr         (dec_instr),
      .dec_pc            (dec_pc),
      .dec_thumb         (dec_thumb),
      .dec_ready         (dec_ready),
`ifdef PREFETCH_STATS_EN
      .stat_fetches      (stat_fetches),
      .stat_flushes      (stat_flushes),
      .stat_discards     (stat_discards),
`endif
      .occupancy         (occupancy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      fetch_enable = 1'b0;
      branch_valid = 1'b0;
      branch_addr  = '0;
      branch_thumb = 1'b0;
      icache_ready = 1'b0;
      dec_ready    = 1'b0;
      tick();
      tick();
      chk("rst_req",   32'(icache_req), 32'd0);
      chk("rst_addr",  icache_addr, 32'h0);
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_occ",   32'(occupancy), 32'd0);
      chk("rst_instr", dec_instr, 32'h0);
      rst = 1'b0;

      // Streaming fetch with decode always ready.
      fetch_enable = 1'b1; icache_ready = 1'b1; dec_ready = 1'b1;
      tick();
      chk("s_req",   32'(icache_req), 32'd1);
      chk("s_addr0", icache_addr, 32'h0);
      tick();
      chk("s_addr4", icache_addr, 32'h4);
      chk("s_pc0",   dec_pc, 32'h0);
      chk("s_occ1",  32'(occupancy), 32'd1);
      tick();
      chk("s_addr8", icache_addr, 32'h8);
      chk("s_pc4",   dec_pc, 32'h4);
      chk("s_ins4",  dec_instr, 32'hE000_0004);
      chk("s_occ1b", 32'(occupancy), 32'd1);

      // Fill the FIFO with decode stalled.
      dec_ready = 1'b0;
      do_reset();
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("f_occ4",  32'(occupancy), 32'd4);
      chk("f_req0",  32'(icache_req), 32'd0);
      chk("f_addr",  icache_addr, 32'h10);
      chk("f_head",  dec_pc, 32'h0);
      tick();
      chk("f_hold",  32'(icache_req), 32'd0);
      dec_ready = 1'b1;
      tick();
      chk("f_occ3",  32'(occupancy), 32'd3);
      chk("f_req1",  32'(icache_req), 32'd1);
      chk("f_addr10", icache_addr, 32'h10);
      chk("f_head4", dec_pc, 32'h4);
      tick();
      chk("f_addr14", icache_addr, 32'h14);
      chk("f_occ3b", 32'(occupancy), 32'd3);

      // Branch to Thumb with three entries held and a transfer at 0x14 in flight.
      dec_ready = 1'b0;
      branch_valid = 1'b1; branch_addr = 32'h103; branch_thumb = 1'b1;
      tick();
      branch_valid = 1'b0;
      chk("b_occ0",  32'(occupancy), 32'd0);
      chk("b_valid", 32'(dec_valid), 32'd0);
      chk("b_addr",  icache_addr, 32'h102);
      chk("b_tmode", 32'(icache_thumb_mode), 32'd1);
`ifdef PREFETCH_STATS_EN
      chk("b_flush", stat_flushes, 32'd1);
      chk("b_disc",  stat_discards, 32'd4);
`endif
      dec_ready = 1'b1;
      tick();
      chk("b_addr104", icache_addr, 32'h104);
      chk("b_pc102",   dec_pc, 32'h102);
      chk("b_thumb",   32'(dec_thumb), 32'd1);
      tick();
      chk("b_addr106", icache_addr, 32'h106);
      chk("b_pc104",   dec_pc, 32'h104);
`ifdef PREFETCH_STATS_EN
      chk("b_fetch",   stat_fetches, 32'd8);
`endif

      // Branch that coincides with the transfer at 0x20; ARM target 0x203 -> 0x200.
      do_reset();
      tick();
      for (int i = 0; i < 8; i++) tick();
      chk("c_addr20", icache_addr, 32'h20);
      branch_valid = 1'b1; branch_addr = 32'h203; branch_thumb = 1'b0;
      tick();
      branch_valid = 1'b0;
      chk("c_addr",  icache_addr, 32'h200);
      chk("c_valid", 32'(dec_valid), 32'd0);
      chk("c_tmode", 32'(icache_thumb_mode), 32'd0);
      tick();
      chk("c_pc200", dec_pc, 32'h200);
      chk("c_ins",   dec_instr, 32'hE000_0200);
      chk("c_addr204", icache_addr, 32'h204);
`ifdef PREFETCH_STATS_EN
      chk("c_disc",  stat_discards, 32'd2);
`endif

      // Cache stall: request and address hold and nothing is pushed.
      icache_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("w_addr", icache_addr, 32'h204);
         chk("w_req",  32'(icache_req), 32'd1);
      end
      chk("w_occ0",  32'(occupancy), 32'd0);
`ifdef PREFETCH_STATS_EN
      chk("w_fetch", stat_fetches, 32'd10);
`endif

      // PC wraps at the top of the address space.
      icache_ready = 1'b1;
      branch_valid = 1'b1; branch_addr = 32'hFFFF_FFFC; branch_thumb = 1'b0;
      tick();
      branch_valid = 1'b0;
      chk("x_addrtop", icache_addr, 32'hFFFF_FFFC);
      tick();
      chk("x_wrap",  icache_addr, 32'h0);
      chk("x_pc",    dec_pc, 32'hFFFF_FFFC);

      // Reset in the middle of a fill.
      dec_ready = 1'b0;
      tick();
      tick();
      chk("r_occ",   32'(occupancy), 32'd3);
      rst = 1'b1;
      tick();
      chk("r_req",   32'(icache_req), 32'd0);
      chk("r_addr",  icache_addr, 32'h0);
      chk("r_occ0",  32'(occupancy), 32'd0);
      chk("r_valid", 32'(dec_valid), 32'd0);
      chk("r_pc",    dec_pc, 32'h0);
      chk("r_instr", dec_instr, 32'h0);
      rst = 1'b0;

      // With fetching disabled the block stays idle.
      fetch_enable = 1'b0;
      tick();
      tick();
      chk("i_req",   32'(icache_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm7tdmi_prefetch_buffer.md
Name: arm7tdmi_prefetch_buffer

Overview:
- Fetch front end that sits directly upstream of the instruction cache's CPU port and feeds the decode stage.
- Holds the fetch PC and issues sequential ARM (+4) or Thumb (+2) requests to the cache.
- Queues returned instructions with their PC in a small FIFO.
- Flushes and redirects on branch; decode consumes entries through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_WIDTH, 32, address width.
- RESET_VECTOR, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_enable  in  1  fetching permitted when high
- branch_valid  in  1  redirect request, one-cycle pulse
- branch_addr  in  ADDR_WIDTH  redirect target
- branch_thumb  in  1  instruction set state at the target
- icache_addr  out  ADDR_WIDTH  fetch address to cache
- icache_req  out  1  fetch request
- icache_thumb_mode  out  1  current Thumb state to cache
- icache_data  in  32  instruction from cache; Thumb data is zero-extended in [15:0]
- icache_ready  in  1  cache accepts and returns data this cycle
- dec_valid  out  1  FIFO head valid
- dec_instr  out  32  head instruction
- dec_pc  out  ADDR_WIDTH  head instruction address
- dec_thumb  out  1  head instruction set state
- dec_ready  in  1  decode consumes head
- occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (synchronous, rst high at posedge):
  - pc=RESET_VECTOR, thumb=0, state=IDLE, FIFO empty.
  - All outputs 0, except icache_addr=RESET_VECTOR.
  - rst mid-fetch discards everything; the cache sees icache_req low in the next cycle.
- States:
  - IDLE: icache_req=0. Go to FETCH when fetch_enable=1.
  - FETCH: icache_req=1. Go to FULL when a push makes the count reach DEPTH. Go to IDLE when fetch_enable=0.
  - FULL: icache_req=0. Go to FETCH when a pop occurs and fetch_enable=1; otherwise go to IDLE.
- icache_req is registered-state decode only; there is no combinational path from dec_ready or icache_ready.
- icache_addr = pc; icache_thumb_mode = thumb.
- Transfer completes in any cycle with icache_req && icache_ready.
- On transfer: push {icache_data, pc, thumb}; pc <= pc+2 if thumb, else pc+4. The increment wraps modulo 2^ADDR_WIDTH.
- While icache_ready=0, icache_req and icache_addr stay stable.
- Pop occurs when dec_valid && dec_ready.
- Simultaneous push and pop leave occupancy unchanged.
- Push is only possible when not full, so overflow is impossible.
- dec_* outputs reflect the FIFO head combinationally from storage; latency from transfer to dec_valid is 1 cycle.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- branch_valid has highest priority over push and pop:
  - FIFO cleared, occupancy=0, dec_valid=0 next cycle.
  - pc <= branch_addr with bits[1:0] cleared if branch_thumb=0, else bit0 cleared; thumb <= branch_thumb.
  - A transfer completing in the same cycle is discarded and the pc is not incremented.
  - Any pop in the same cycle is ignored.
  - State: FETCH if fetch_enable=1, else IDLE.
- fetch_enable=0 stops new requests only. The FIFO keeps draining to decode.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- When defined, adds three outputs, each 32-bit and wrapping, reset to 0:
  - stat_fetches: accepted transfers, including discarded ones.
  - stat_flushes: branch_valid pulses.
  - stat_discards: entries dropped by flush, i.e. occupancy at flush plus 1 if a transfer coincided.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, fetch_enable=1, icache_ready=1, dec_ready=1 -> icache_addr 0x0, 0x4, 0x8 on consecutive cycles; dec_pc follows one cycle later; occupancy stays ≤1.
- dec_ready=0 with DEPTH=4 -> four pushes (0x0..0xC), then icache_req=0 and occupancy=4. Raise dec_ready -> pops resume and the next request is 0x10.
- branch_valid with branch_addr=0x103, branch_thumb=1, while FIFO holds 3 entries -> next cycle occupancy=0 and icache_addr=0x102. Subsequent addresses are 0x104, 0x106 with dec_thumb=1.
- Branch coincident with a transfer at 0x20 -> that data is never presented; next request is to the branch target.
- icache_ready low for 5 cycles -> icache_addr and icache_req stable, no push; with PREFETCH_STATS_EN, stat_fetches is unchanged.
- pc=0xFFFF_FFFC ARM, transfer -> next icache_addr=0x0000_0000. Assert rst mid-fill -> all outputs back to reset values the next cycle.
